// File: rtl/btb_pkg.sv
// Shared constants and the entry record for the branch target buffer.
// Replacement policy is chosen by BTB_LRU_EN (true LRU) or FIFO by default.
package btb_pkg;

  localparam int BTB_ENTRIES = 8;
  localparam int BTB_IDX_W   = $clog2(BTB_ENTRIES);
  localparam int TAG_LSB     = 2;
  localparam int TAG_W       = 32 - TAG_LSB;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

endpackage

// File: rtl/btb_lookup_update_if.sv
// Fetch/execute side bundle of the branch target buffer.
// master = pipeline, slave = BTB.
interface btb_lookup_update_if
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) ();

  logic [31:0]        IF_PC;
  logic               Hit;
  logic [IDX_W-1:0]   Hit_Index;
  logic [31:0]        PredTarget;
  logic               EX_Valid;
  logic [31:0]        EX_PC;
  logic               EX_Taken;
  logic [31:0]        EX_Target;
  logic               EX_Hit;
  logic [IDX_W-1:0]   EX_Index;
  logic [ENTRIES-1:0] Alloc_OH;

  modport master (
    output IF_PC, EX_Valid, EX_PC,
    output EX_Taken, EX_Target,
    input  Hit, Hit_Index, PredTarget,
    input  EX_Hit, EX_Index, Alloc_OH
  );

  modport slave (
    input  IF_PC, EX_Valid, EX_PC,
    input  EX_Taken, EX_Target,
    output Hit, Hit_Index, PredTarget,
    output EX_Hit, EX_Index, Alloc_OH
  );

endinterface

// File: rtl/btb_victim_sel.sv
// Victim choice: lowest invalid entry, else LRU (BTB_LRU_EN)
// or FIFO pointer. Purely combinational.
module btb_victim_sel
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic [ENTRIES-1:0]            valid,
`ifdef BTB_LRU_EN
  input  logic [ENTRIES-1:0][IDX_W-1:0] age,
`else
  input  logic [IDX_W-1:0]              ptr,
`endif
  output logic [IDX_W-1:0]              victim
);

  logic found;

  always_comb begin
    victim = '0;
    found  = 1'b0;
    // descending scan so the lowest invalid index wins
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim = IDX_W'(i);
        found  = 1'b1;
      end
    end
    if (!found) begin
`ifdef BTB_LRU_EN
      for (int i = 0; i < ENTRIES; i++) begin
        if (age[i] == IDX_W'(ENTRIES - 1))
          victim = IDX_W'(i);
      end
`else
      victim = ptr;
`endif
    end
  end

endmodule

// File: rtl/btb_lookup_update.sv
// Fully-associative BTB: combinational IF/EX lookup, EX-stage update.
// BTB_LRU_EN selects true-LRU replacement; FIFO otherwise.
module btb_lookup_update
  import btb_pkg::*;
#(
  parameter int ENTRIES = BTB_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input logic                CLK,
  input logic                RST_N,
  input logic                FLUSH,
  btb_lookup_update_if.slave bus
);

  btb_entry_t         tbl [ENTRIES];
  logic [ENTRIES-1:0] valid_vec;
  logic [ENTRIES-1:0] alloc_oh;

  logic               if_hit;
  logic [IDX_W-1:0]   if_idx;
  logic [31:0]        if_tgt;
  logic               ex_hit;
  logic [IDX_W-1:0]   ex_idx;

  logic [IDX_W-1:0]   victim;
  logic               alloc;
  logic               retarget;

  logic               unused_pc;
  assign unused_pc = ^{bus.IF_PC[1:0], bus.EX_PC[1:0]};

  always_comb begin
    for (int i = 0; i < ENTRIES; i++)
      valid_vec[i] = tbl[i].valid;
  end

  // tags are unique, so OR-merging the match is a clean mux
  always_comb begin
    if_hit = 1'b0;
    if_idx = '0;
    if_tgt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tbl[i].valid &&
          tbl[i].tag == bus.IF_PC[31:TAG_LSB]) begin
        if_hit = 1'b1;
        if_idx = if_idx | IDX_W'(i);
        if_tgt = if_tgt | tbl[i].target;
      end
    end
  end

  always_comb begin
    ex_hit = 1'b0;
    ex_idx = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (tbl[i].valid &&
          tbl[i].tag == bus.EX_PC[31:TAG_LSB]) begin
        ex_hit = 1'b1;
        ex_idx = ex_idx | IDX_W'(i);
      end
    end
  end

  assign bus.Hit        = if_hit;
  assign bus.Hit_Index  = if_idx;
  assign bus.PredTarget = if_tgt;
  assign bus.EX_Hit     = ex_hit;
  assign bus.EX_Index   = ex_idx;
  assign bus.Alloc_OH   = alloc_oh;

  assign alloc    = bus.EX_Valid && !ex_hit && bus.EX_Taken;
  assign retarget = bus.EX_Valid && ex_hit && bus.EX_Taken;

`ifdef BTB_LRU_EN
  logic [ENTRIES-1:0][IDX_W-1:0] age;
  logic                          touch;
  logic [IDX_W-1:0]              touch_idx;
  logic [IDX_W-1:0]              ref_age;

  assign touch     = bus.EX_Valid && (ex_hit || alloc);
  assign touch_idx = ex_hit ? ex_idx : victim;

  // an invalid slot counts as oldest so every live entry ages
  always_comb begin
    ref_age = IDX_W'(ENTRIES - 1);
    if (ex_hit)
      ref_age = age[ex_idx];
    else if (valid_vec[victim])
      ref_age = age[victim];
  end

  btb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim (
    .valid  (valid_vec),
    .age    (age),
    .victim (victim)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      age <= '0;
    end else if (FLUSH) begin
      age <= '0;
    end else if (touch) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (IDX_W'(i) == touch_idx)
          age[i] <= '0;
        else if (valid_vec[i] && age[i] < ref_age)
          age[i] <= age[i] + 1'b1;
      end
    end
  end
`else
  logic [IDX_W-1:0] ptr;

  btb_victim_sel #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_victim (
    .valid  (valid_vec),
    .ptr    (ptr),
    .victim (victim)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ptr <= '0;
    end else if (FLUSH) begin
      ptr <= '0;
    end else if (alloc && &valid_vec) begin
      ptr <= ptr + 1'b1;
    end
  end
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i] <= '0;
      alloc_oh <= '0;
    end else if (FLUSH) begin
      for (int i = 0; i < ENTRIES; i++)
        tbl[i].valid <= 1'b0;
      alloc_oh <= '0;
    end else begin
      alloc_oh <= '0;
      if (retarget)
        tbl[ex_idx].target <= bus.EX_Target;
      if (alloc) begin
        tbl[victim].valid  <= 1'b1;
        tbl[victim].tag    <= bus.EX_PC[31:TAG_LSB];
        tbl[victim].target <= bus.EX_Target;
        alloc_oh <= ENTRIES'(1) << victim;
      end
    end
  end

endmodule

// File: tb/tb_btb_lookup_update.sv
// Directed bench for btb_lookup_update.
// Expected victims follow BTB_LRU_EN when defined.
module tb_btb_lookup_update;
  import btb_pkg::*;

`ifdef BTB_LRU_EN
  localparam int VIC = 1;
`else
  localparam int VIC = 0;
`endif

  logic CLK   = 1'b0;
  logic RST_N = 1'b0;
  logic FLUSH = 1'b0;

  always #5 CLK = ~CLK;

  btb_lookup_update_if bus ();

  btb_lookup_update dut (
    .CLK   (CLK),
    .RST_N (RST_N),
    .FLUSH (FLUSH),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] pc0;
  logic [31:0] old0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h exp %h",
               tag, got, exp);
  endtask

  task automatic ex_op(input logic [31:0] pc,
                       input logic tk,
                       input logic [31:0] tg);
    @(negedge CLK);
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = pc;
    bus.EX_Taken  = tk;
    bus.EX_Target = tg;
    @(negedge CLK);
    bus.EX_Valid  = 1'b0;
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    bus.IF_PC = pc;
    #1;
  endtask

  initial begin
    bus.IF_PC     = '0;
    bus.EX_Valid  = 1'b0;
    bus.EX_PC     = '0;
    bus.EX_Taken  = 1'b0;
    bus.EX_Target = '0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;

    look(32'h0040_0010);
    chk("rst_hit", 32'(bus.Hit), 0);
    chk("rst_idx", 32'(bus.Hit_Index), 0);
    chk("rst_pred", bus.PredTarget, 0);
    chk("rst_exhit", 32'(bus.EX_Hit), 0);
    chk("rst_exidx", 32'(bus.EX_Index), 0);
    chk("rst_alloc", 32'(bus.Alloc_OH), 0);

    ex_op(32'h0040_0010, 1'b1, 32'h0040_0040);
    chk("a0_oh", 32'(bus.Alloc_OH), 32'h01);
    chk("a0_hit", 32'(bus.Hit), 1);
    chk("a0_idx", 32'(bus.Hit_Index), 0);
    chk("a0_pred", bus.PredTarget, 32'h0040_0040);

    @(negedge CLK);
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = 32'h0040_0020;
    bus.EX_Taken  = 1'b0;
    bus.EX_Target = 32'h99;
    #1;
    chk("nt_exhit", 32'(bus.EX_Hit), 0);
    @(negedge CLK);
    bus.EX_Valid = 1'b0;
    #1;
    chk("nt_oh", 32'(bus.Alloc_OH), 0);
    look(32'h0040_0020);
    chk("nt_hit", 32'(bus.Hit), 0);

    @(negedge CLK);
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = 32'h400;
    bus.EX_Taken  = 1'b1;
    bus.EX_Target = 32'h444;
    #2 RST_N = 1'b0;
    @(posedge CLK);
    #1;
    chk("mr_oh", 32'(bus.Alloc_OH), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    bus.EX_Valid = 1'b0;
    look(32'h0040_0010);
    chk("mr_hit_a", 32'(bus.Hit), 0);
    look(32'h400);
    chk("mr_hit_b", 32'(bus.Hit), 0);

    for (int i = 0; i < 8; i++) begin
      ex_op(32'h100 + 32'(4 * i), 1'b1,
            32'h1100 + 32'(4 * i));
      chk("fill_oh", 32'(bus.Alloc_OH),
          32'h1 << i);
    end
    look(32'h11C);
    chk("fill_hit", 32'(bus.Hit), 1);
    chk("fill_idx", 32'(bus.Hit_Index), 7);
    chk("fill_pred", bus.PredTarget, 32'h111C);

    @(negedge CLK);
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = 32'h100;
    bus.EX_Taken  = 1'b1;
    bus.EX_Target = 32'h1100;
    #1;
    chk("rh_exhit", 32'(bus.EX_Hit), 1);
    chk("rh_exidx", 32'(bus.EX_Index), 0);
    @(negedge CLK);
    bus.EX_Valid = 1'b0;
    #1;
    chk("rh_oh", 32'(bus.Alloc_OH), 0);

    ex_op(32'h200, 1'b1, 32'h2200);
    chk("rep_oh", 32'(bus.Alloc_OH), 32'h1 << VIC);
    look(32'h200);
    chk("rep_hit", 32'(bus.Hit), 1);
    chk("rep_idx", 32'(bus.Hit_Index), VIC);
    chk("rep_pred", bus.PredTarget, 32'h2200);
    look(32'h100);
    chk("rep_100", 32'(bus.Hit), (VIC != 0) ? 1 : 0);
    look(32'h104);
    chk("rep_104", 32'(bus.Hit), (VIC != 1) ? 1 : 0);

    pc0  = (VIC == 0) ? 32'h200 : 32'h100;
    old0 = (VIC == 0) ? 32'h2200 : 32'h1100;
    @(negedge CLK);
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = pc0;
    bus.EX_Taken  = 1'b1;
    bus.EX_Target = 32'h500;
    bus.IF_PC     = pc0;
    #1;
    chk("rt_old", bus.PredTarget, old0);
    chk("rt_idx", 32'(bus.Hit_Index), 0);
    @(posedge CLK);
    #1;
    chk("rt_new", bus.PredTarget, 32'h500);
    @(negedge CLK);
    bus.EX_Valid = 1'b0;

    @(negedge CLK);
    FLUSH         = 1'b1;
    bus.EX_Valid  = 1'b1;
    bus.EX_PC     = 32'h300;
    bus.EX_Taken  = 1'b1;
    bus.EX_Target = 32'h333;
    @(negedge CLK);
    FLUSH        = 1'b0;
    bus.EX_Valid = 1'b0;
    #1;
    chk("fl_oh", 32'(bus.Alloc_OH), 0);
    look(pc0);
    chk("fl_hit0", 32'(bus.Hit), 0);
    look(32'h300);
    chk("fl_hit300", 32'(bus.Hit), 0);
    look(32'h104);
    chk("fl_hit104", 32'(bus.Hit), 0);

    ex_op(32'h600, 1'b1, 32'h666);
    chk("pf_oh", 32'(bus.Alloc_OH), 32'h01);
    look(32'h600);
    chk("pf_hit", 32'(bus.Hit), 1);
    chk("pf_pred", bus.PredTarget, 32'h666);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
